// File: rtl/fp_addsub_sched.sv
// Round-robin front end that shares one fp add/sub pipeline between NUM_REQ requesters,
// tags each issue with its requester ID and routes results and sticky IEEE flags back.
module fp_addsub_sched #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  input  logic [3*NUM_REQ-1:0]    req_rm,
  output logic [31:0]             pipe_in1,
  output logic [31:0]             pipe_in2,
  output logic [2:0]              pipe_rm,
  output logic                    pipe_valid_in,
  input  logic [31:0]             pipe_out,
  input  logic                    pipe_overflow,
  input  logic                    pipe_underflow,
  input  logic                    pipe_inexact,
  input  logic                    pipe_invalid,
  input  logic                    pipe_valid_out,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic [3:0]              rsp_flags,
  output logic [4*NUM_REQ-1:0]    sticky_flags,
  input  logic [NUM_REQ-1:0]      flag_clr,
  output logic                    seq_error
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int MW  = $clog2(PIPE_LAT + 1);
  localparam logic [IDW:0]         NUM_REQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0]       LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT0  = NUM_REQ'(1);
  localparam logic [MW-1:0]        MASK_INIT = MW'(PIPE_LAT);

  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 grant_vld;
  logic [IDW-1:0]       grant_off, grant_id;
  logic [IDW:0]         grant_sum;
  logic [31:0]          sel_a, sel_b;
  logic                 sel_sub;
  logic [2:0]           sel_rm;

  logic [31:0]          pipe_in1_q, pipe_in2_q;
  logic [2:0]           pipe_rm_q;
  logic                 pipe_valid_in_q;
  logic [IDW-1:0]       issue_id_q;
  logic [PIPE_LAT-1:0]  tag_vld_q;
  logic [IDW-1:0]       tag_id_q [PIPE_LAT];
  logic [MW-1:0]        mask_q;

  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [31:0]          rsp_data_q;
  logic [3:0]           rsp_flags_q;
  logic [4*NUM_REQ-1:0] sticky_q, sticky_d;
  logic                 seq_error_q;

  logic                 rsp_fire, tag_mismatch;
  logic [IDW-1:0]       last_id;
  logic [3:0]           new_flags;

  // Rotate requests so bit 0 is the current round-robin head
  assign req_dbl = {req_valid, req_valid} >> rr_ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    grant_vld = 1'b0;
    grant_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_vld = 1'b1;
        grant_off = IDW'(k);
      end
    end
  end

  assign grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
  assign grant_id  = (grant_sum >= NUM_REQ_W) ? IDW'(grant_sum - NUM_REQ_W) : grant_sum[IDW-1:0];
  assign req_ready = grant_vld ? (ONE_HOT0 << grant_id) : '0;
  assign rr_ptr_d  = !grant_vld ? rr_ptr_q : ((grant_id == LAST_ID) ? '0 : grant_id + IDW'(1));

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    sel_rm  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
        sel_rm  = req_rm[3*i +: 3];
      end
    end
  end

  assign rsp_fire     = pipe_valid_out && tag_vld_q[PIPE_LAT-1];
  assign tag_mismatch = pipe_valid_out ^ tag_vld_q[PIPE_LAT-1];
  assign last_id      = tag_id_q[PIPE_LAT-1];
  assign new_flags    = {pipe_invalid, pipe_overflow, pipe_underflow, pipe_inexact};

  // A response's flags land even if the same requester is clearing this cycle
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      sticky_d[4*i +: 4] = flag_clr[i] ? 4'b0000 : sticky_q[4*i +: 4];
      if (rsp_fire && (last_id == IDW'(i)))
        sticky_d[4*i +: 4] = sticky_d[4*i +: 4] | new_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= '0;
      pipe_in1_q      <= '0;
      pipe_in2_q      <= '0;
      pipe_rm_q       <= '0;
      pipe_valid_in_q <= 1'b0;
      issue_id_q      <= '0;
      tag_vld_q       <= '0;
      for (int s = 0; s < PIPE_LAT; s++) tag_id_q[s] <= '0;
      mask_q          <= MASK_INIT;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      rsp_flags_q     <= '0;
      sticky_q        <= '0;
      seq_error_q     <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      pipe_valid_in_q <= grant_vld;
      if (grant_vld) begin
        pipe_in1_q <= sel_a;
        pipe_in2_q <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
        pipe_rm_q  <= sel_rm;
        issue_id_q <= grant_id;
      end
      tag_vld_q[0] <= pipe_valid_in_q;
      tag_id_q[0]  <= issue_id_q;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      // Results from before reset may still drain out of the pipeline
      if (mask_q != '0) mask_q <= mask_q - MW'(1);
      if ((mask_q == '0) && tag_mismatch) seq_error_q <= 1'b1;
      rsp_valid_q <= rsp_fire ? (ONE_HOT0 << last_id) : '0;
      if (rsp_fire) begin
        rsp_data_q  <= pipe_out;
        rsp_flags_q <= new_flags;
      end
      sticky_q <= sticky_d;
    end
  end

  assign pipe_in1      = pipe_in1_q;
  assign pipe_in2      = pipe_in2_q;
  assign pipe_rm       = pipe_rm_q;
  assign pipe_valid_in = pipe_valid_in_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_flags     = rsp_flags_q;
  assign sticky_flags  = sticky_q;
  assign seq_error     = seq_error_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: a stand-in arithmetic pipeline, a request-side predictor
// feeding a scoreboard queue, and a response-side monitor with a sticky-flag model.
module tb_fp_addsub_sched;

  localparam int N = 4;
  localparam int L = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, req_sub, flag_clr, rsp_valid;
  logic [32*N-1:0]   req_a, req_b;
  logic [3*N-1:0]    req_rm;
  logic [31:0]       pipe_in1, pipe_in2, pipe_out, rsp_data;
  logic [2:0]        pipe_rm;
  logic              pipe_valid_in, pipe_valid_out;
  logic              pipe_overflow, pipe_underflow, pipe_inexact, pipe_invalid;
  logic [3:0]        rsp_flags;
  logic [4*N-1:0]    sticky_flags;
  logic              seq_error;
  logic              inject = 1'b0;

  fp_addsub_sched #(.NUM_REQ(N), .PIPE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_rm(req_rm),
    .pipe_in1(pipe_in1), .pipe_in2(pipe_in2), .pipe_rm(pipe_rm), .pipe_valid_in(pipe_valid_in),
    .pipe_out(pipe_out), .pipe_overflow(pipe_overflow), .pipe_underflow(pipe_underflow),
    .pipe_inexact(pipe_inexact), .pipe_invalid(pipe_invalid), .pipe_valid_out(pipe_valid_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .sticky_flags(sticky_flags), .flag_clr(flag_clr), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] data; logic [3:0] flags; int due; } exp_t;
  exp_t sb_q[$];

  // Stand-in arithmetic: exact for the directed cases, an arbitrary but deterministic
  // function of the operands and rounding mode otherwise. Returns {flags, result}.
  function automatic logic [35:0] pipe_model(input logic [31:0] a, input logic [31:0] b2,
                                             input logic [2:0] rm);
    if (a[30:0] == 31'h7F800000 && b2[30:0] == 31'h7F800000 && a[31] != b2[31])
      return {4'b1000, 32'h7FC00000};
    if (a == 32'h40400000 && b2 == 32'hBF800000)
      return {4'b0000, 32'h40000000};
    return {a[3:0] ^ b2[7:4], a + b2 + {29'd0, rm}};
  endfunction

  // Shared pipeline stand-in; deliberately not reset so stale results can emerge after reset
  bit        sv  [L];
  bit [31:0] s1  [L];
  bit [31:0] s2  [L];
  bit [2:0]  srm [L];
  logic [35:0] stub_res;
  always @(posedge clk) begin
    sv[0]  <= pipe_valid_in;
    s1[0]  <= pipe_in1;
    s2[0]  <= pipe_in2;
    srm[0] <= pipe_rm;
    for (int k = 1; k < L; k++) begin
      sv[k]  <= sv[k-1];
      s1[k]  <= s1[k-1];
      s2[k]  <= s2[k-1];
      srm[k] <= srm[k-1];
    end
  end
  assign stub_res       = pipe_model(s1[L-1], s2[L-1], srm[L-1]);
  assign pipe_out       = stub_res[31:0];
  assign {pipe_invalid, pipe_overflow, pipe_underflow, pipe_inexact} = stub_res[35:32];
  assign pipe_valid_out = sv[L-1] | inject;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predictor: expected grant from the round-robin rule, expected response into the queue
  int rr_m = 0;
  initial begin
    int g;
    logic [N-1:0]  exp_rdy;
    logic [31:0]   b2;
    logic [35:0]   r;
    forever begin
      @(negedge clk);
      if (!rst_n) rr_m = 0;
      else begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
        exp_rdy = (g < 0) ? '0 : (N'(1) << g);
        check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        if (g >= 0) begin
          b2 = req_b[32*g +: 32];
          b2[31] = b2[31] ^ req_sub[g];
          r = pipe_model(req_a[32*g +: 32], b2, req_rm[3*g +: 3]);
          sb_q.push_back('{id: g, data: r[31:0], flags: r[35:32], due: cyc + L + 2});
          rr_m = (g + 1) % N;
        end
      end
    end
  end

  // Monitor: pops and compares whenever a response is presented, tracks sticky flags
  logic [4*N-1:0] sticky_m = '0;
  logic [N-1:0]   prev_clr = '0;
  initial begin
    exp_t        e;
    int          rid;
    logic [3:0]  rfl;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sticky_m = '0;
        prev_clr = '0;
      end else begin
        rid = -1;
        rfl = '0;
        if (rsp_valid != '0) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", {60'd0, rsp_valid}, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("rsp_valid", {60'd0, rsp_valid}, {60'd0, N'(1) << e.id});
            check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
            check("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flags});
            check("rsp_cycle", 64'(cyc), 64'(e.due));
            rid = e.id;
            rfl = e.flags;
          end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
          e = sb_q.pop_front();
          check("rsp_missing", 64'd0, {60'd0, N'(1) << e.id});
        end
        for (int i = 0; i < N; i++) begin
          if (i == rid) sticky_m[4*i +: 4] = (prev_clr[i] ? 4'b0000 : sticky_m[4*i +: 4]) | rfl;
          else if (prev_clr[i]) sticky_m[4*i +: 4] = 4'b0000;
        end
        check("sticky_flags", {48'd0, sticky_flags}, {48'd0, sticky_m});
        prev_clr = flag_clr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] rm);
    req_valid[id]       = 1'b1;
    req_a[32*id +: 32]  = a;
    req_b[32*id +: 32]  = b;
    req_sub[id]         = s;
    req_rm[3*id +: 3]   = rm;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    tick();
  endtask

  task automatic check_reset_values();
    check("rst_pipe_valid_in", {63'd0, pipe_valid_in}, 64'd0);
    check("rst_pipe_in1", {32'd0, pipe_in1}, 64'd0);
    check("rst_pipe_in2", {32'd0, pipe_in2}, 64'd0);
    check("rst_pipe_rm", {61'd0, pipe_rm}, 64'd0);
    check("rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("rst_rsp_flags", {60'd0, rsp_flags}, 64'd0);
    check("rst_sticky", {48'd0, sticky_flags}, 64'd0);
    check("rst_seq_error", {63'd0, seq_error}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; req_rm = '0; flag_clr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    check("rst_req_ready", {60'd0, req_ready}, 64'd0);
    rst_n = 1'b1;
    repeat (L + 1) tick();

    // Round-robin fairness with all four requesting
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom), 3'($urandom));
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_grant", {60'd0, req_ready}, {60'd0, N'(1) << (k % N)});
      tick();
    end
    clear_reqs();
    drain();

    // Single subtract 3.0 - 1.0
    set_req(0, 32'h40400000, 32'h3F800000, 1'b1, 3'b001);
    #1;
    check("sub_ready", {60'd0, req_ready}, 64'd1);
    tick();
    clear_reqs();
    check("sub_valid_in", {63'd0, pipe_valid_in}, 64'd1);
    check("sub_in1", {32'd0, pipe_in1}, 64'h40400000);
    check("sub_in2", {32'd0, pipe_in2}, 64'hBF800000);
    check("sub_rm", {61'd0, pipe_rm}, 64'd1);
    tick();
    check("sub_valid_in_drop", {63'd0, pipe_valid_in}, 64'd0);
    repeat (L) tick();
    check("sub_rsp_valid", {60'd0, rsp_valid}, 64'b0001);
    check("sub_rsp_data", {32'd0, rsp_data}, 64'h40000000);
    drain();

    // Back-to-back routing: requester 2 then requester 1
    set_req(2, 32'h12345678, 32'h0BADF00D, 1'b0, 3'd3);
    tick();
    clear_reqs();
    set_req(1, 32'hCAFEBABE, 32'h80000001, 1'b1, 3'd4);
    tick();
    clear_reqs();
    repeat (L) tick();
    check("b2b_first", {60'd0, rsp_valid}, 64'b0100);
    tick();
    check("b2b_second", {60'd0, rsp_valid}, 64'b0010);
    drain();

    // Sticky flags: inf - inf on requester 3, then a clear coincident with an inexact result
    flag_clr = 4'b1000;
    tick();
    flag_clr = '0;
    set_req(3, 32'h7F800000, 32'h7F800000, 1'b1, 3'd0);
    tick();
    clear_reqs();
    repeat (L + 1) tick();
    check("inf_rsp_data", {32'd0, rsp_data}, 64'h7FC00000);
    check("inf_sticky3", {60'd0, sticky_flags[15:12]}, 64'b1000);
    drain();
    set_req(3, 32'h3F800001, 32'h00000000, 1'b0, 3'd0);
    tick();
    clear_reqs();
    repeat (L) tick();
    flag_clr[3] = 1'b1;
    tick();
    flag_clr = '0;
    check("clr_rsp_valid", {60'd0, rsp_valid}, 64'b1000);
    check("clr_sticky3", {60'd0, sticky_flags[15:12]}, 64'b0001);
    drain();

    // Randomized traffic with occasional clears
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
      end
      req_sub  = N'($urandom);
      req_rm   = 12'($urandom);
      flag_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      tick();
    end
    clear_reqs();
    flag_clr = '0;
    drain();
    check("rand_seq_error", {63'd0, seq_error}, 64'd0);

    // Sequencing error: a result with no matching tag
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("seq_err_set", {63'd0, seq_error}, 64'd1);
    check("seq_err_no_rsp", {60'd0, rsp_valid}, 64'd0);
    repeat (5) tick();
    check("seq_err_sticky", {63'd0, seq_error}, 64'd1);

    // Reset with three operations in flight
    set_req(0, $urandom, $urandom, 1'b0, 3'd0);
    tick();
    clear_reqs();
    set_req(1, $urandom, $urandom, 1'b1, 3'd1);
    tick();
    clear_reqs();
    set_req(2, $urandom, $urandom, 1'b0, 3'd2);
    tick();
    clear_reqs();
    tick();
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset_values();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    check("stale_seq_error", {63'd0, seq_error}, 64'd0);
    check("stale_rsp_valid", {60'd0, rsp_valid}, 64'd0);

    // Normal operation resumes after reset
    set_req(1, 32'h40400000, 32'h3F800000, 1'b1, 3'd0);
    tick();
    clear_reqs();
    repeat (L + 1) tick();
    check("post_rst_rsp", {60'd0, rsp_valid}, 64'b0010);
    check("post_rst_data", {32'd0, rsp_data}, 64'h40000000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
